contador_controle: RTL and testbench

- Sequencing controller for the key-decoder datapath (4 key lines A=+1, B=+2, C=+3, D=negative in; 8-bit two's-complement step out).
- Synchronises and debounces the raw key lines and presents a stable key vector to the decoder.
- On each accepted press, reads the decoder's signed step back and adds it to a saturating signed 8-bit running total.
- Sits between the board switches and the display / total logic of the counter-adder.

---
 rtl/contador_controle.sv | 128 ++++++++++++
 tb/tb_contador_controle.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_controle.sv
// Key-line sequencer: synchronises and debounces the raw keys, presents a stable vector to
// the decoder and accumulates the returned signed step into a saturating 8-bit total.
module contador_controle #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_c,
  input  logic       key_d,
  input  logic       clr,
  output logic [3:0] keys_q,
  input  logic [7:0] step_in,
  output logic [7:0] total,
  output logic       step_valid,
  output logic       ovf,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DebMax = CNT_W'(DEB_CYCLES);

  typedef enum logic [1:0] {StIdle, StDeb, StApply, StRel} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       keys_d;
  logic [7:0]       total_q, total_d;
  logic             step_valid_q, step_valid_d;
  logic             ovf_q, ovf_d;
  logic             pressed;
  logic [8:0]       sum;

  // sync2_q is the synchronised key vector; cnt_q is how long it has held its current value
  assign pressed = |sync2_q[2:0];
  assign sum     = {total_q[7], total_q} + {step_in[7], step_in};

  always_comb begin
    sync1_d = {key_d, key_c, key_b, key_a};
    sync2_d = sync1_q;
    if (sync2_d != sync2_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q >= DebMax) begin
      cnt_d = DebMax;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    state_d      = state_q;
    keys_d       = keys_q;
    total_d      = total_q;
    ovf_d        = ovf_q;
    step_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        keys_d = 4'b0000;
        if (pressed) state_d = StDeb;
      end
      StDeb: begin
        if (!pressed) begin
          state_d = StIdle;
        end else if (cnt_q == DebMax) begin
          keys_d  = sync2_q;
          state_d = StApply;
        end
      end
      StApply: begin
        step_valid_d = 1'b1;
        state_d      = StRel;
        // The two top bits of the 9-bit sum disagree only on signed overflow
        case (sum[8:7])
          2'b01: begin
            total_d = 8'h7f;
            ovf_d   = 1'b1;
          end
          2'b10: begin
            total_d = 8'h80;
            ovf_d   = 1'b1;
          end
          default: total_d = sum[7:0];
        endcase
      end
      StRel: begin
        if (!pressed && cnt_q == DebMax) begin
          keys_d  = 4'b0000;
          state_d = StIdle;
        end
      end
    endcase

    if (clr) begin
      total_d = 8'h00;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      keys_q       <= '0;
      total_q      <= '0;
      step_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      keys_q       <= keys_d;
      total_q      <= total_d;
      step_valid_q <= step_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign total      = total_q;
  assign step_valid = step_valid_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_contador_controle.sv
// Randomised bench for contador_controle: a press-level model tracks the saturating total,
// the sticky overflow flag, one step per press and the press-to-step latency.
module tb_contador_controle;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n, key_a, key_b, key_c, key_d, clr;
  logic [3:0] keys_q;
  logic [7:0] step_in, total;
  logic       step_valid, ovf, busy;
  logic       dec_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int exp_total = 0;
  int exp_ovf   = 0;

  contador_controle #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_a      (key_a),
    .key_b      (key_b),
    .key_c      (key_c),
    .key_d      (key_d),
    .clr        (clr),
    .keys_q     (keys_q),
    .step_in    (step_in),
    .total      (total),
    .step_valid (step_valid),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: weighted sum of a/b/c, negated when d is set
  function automatic logic [7:0] decode(input logic [3:0] k);
    int mag;
    mag = int'(k[0]) + 2 * int'(k[1]) + 3 * int'(k[2]);
    return 8'(k[3] ? -mag : mag);
  endfunction

  assign step_in = dec_zero ? 8'h00 : decode(keys_q);

  always @(negedge clk) if (step_valid === 1'b1) pulses++;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_d, key_c, key_b, key_a} = k;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "/total"}, $signed(total), exp_total);
    check_eq({tag, "/ovf"}, ovf, exp_ovf);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "/total"}, total, 0);
    check_eq({tag, "/keys_q"}, keys_q, 0);
    check_eq({tag, "/step_valid"}, step_valid, 0);
    check_eq({tag, "/ovf"}, ovf, 0);
    check_eq({tag, "/busy"}, busy, 0);
  endtask

  // One full press: k1 accepted, k2 swapped in while held, then released
  task automatic press(input logic [3:0] k1, input logic [3:0] k2, input int hold,
                       input int rel, input string tag);
    int lat;
    int p0;
    int step;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    p0   = pulses;
    set_keys(k1);
    while (!seen && lat < 3 * DEB + 10) begin
      @(posedge clk);
      #1;
      lat++;
      seen = (step_valid === 1'b1);
    end
    check_eq({tag, "/seen"}, seen, 1);
    step = dec_zero ? 0 : int'($signed(decode(k1)));
    exp_total = exp_total + step;
    if (exp_total > 127) begin
      exp_total = 127;
      exp_ovf   = 1;
    end else if (exp_total < -128) begin
      exp_total = -128;
      exp_ovf   = 1;
    end
    if (seen) begin
      check_eq({tag, "/latency"}, (lat >= DEB + 2 && lat <= DEB + 4) ? DEB + 3 : lat, DEB + 3);
      check_eq({tag, "/keys_q"}, keys_q, k1);
      check_model({tag, "/apply"});
    end
    @(negedge clk);
    set_keys(k2);
    cyc(hold);
    set_keys(4'b0000);
    cyc(rel);
    check_eq({tag, "/pulses"}, pulses - p0, 1);
    check_eq({tag, "/idle"}, busy, 0);
    check_model({tag, "/after"});
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_total = 0;
    exp_ovf   = 0;
    check_model(tag);
  endtask

  function automatic logic [3:0] rand_keys();
    logic [3:0] k;
    k[2:0] = 3'($urandom_range(1, 7));
    k[3]   = 1'($urandom_range(0, 1));
    return k;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    rst_n    = 1'b0;
    clr      = 1'b0;
    dec_zero = 1'b0;
    set_keys(4'b0000);
    cyc(3);
    check_zero("reset");
    rst_n = 1'b1;
    cyc(2);
    check_zero("post_reset");

    press(4'b0011, 4'b0011, 10, 10, "ab_plus3");

    do_clr("clr_idle");
    press(4'b1011, 4'b1011, 3, DEB + 4, "abd_minus3_1");
    press(4'b1011, 4'b1011, 3, DEB + 4, "abd_minus3_2");
    check_eq("minus6_hex", total, 8'hfa);

    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      set_keys((i % 2 == 0) ? 4'b0010 : 4'b0000);
      cyc(2);
    end
    check_eq("bounce/pulses", pulses - p0, 0);
    check_model("bounce");
    press(4'b0001, 4'b0001, 5, DEB + 4, "after_bounce");

    do_clr("clr_before_sat");
    for (int i = 0; i < 43; i++) press(4'b0011, 4'b0011, 1, DEB + 4, "sat_pos");
    check_eq("sat_pos/total127", total, 8'h7f);

    // clr landing on the apply cycle must win over the step
    p0 = pulses;
    set_keys(4'b0001);
    n = 0;
    while (keys_q == 4'b0000 && n < 3 * DEB + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("clr_apply/latched", keys_q, 4'b0001);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_eq("clr_apply/step_valid", step_valid, 1);
    check_eq("clr_apply/total", total, 0);
    check_eq("clr_apply/ovf", ovf, 0);
    @(negedge clk);
    clr = 1'b0;
    set_keys(4'b0000);
    cyc(DEB + 4);
    check_eq("clr_apply/pulses", pulses - p0, 1);
    exp_total = 0;
    exp_ovf   = 0;
    check_model("clr_apply/after");

    press(4'b0010, 4'b0011, 8, DEB + 4, "rel_change");

    set_keys(4'b0001);
    cyc(3);
    check_eq("rst_deb/busy", busy, 1);
    p0 = pulses;
    rst_n = 1'b0;
    cyc(1);
    check_zero("rst_deb");
    set_keys(4'b0000);
    cyc(1);
    rst_n = 1'b1;
    cyc(DEB + 6);
    exp_total = 0;
    exp_ovf   = 0;
    check_eq("rst_deb/pulses", pulses - p0, 0);
    check_model("rst_deb/after");

    p0 = pulses;
    set_keys(4'b1000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("d_only/busy", busy, 0);
    end
    set_keys(4'b0000);
    cyc(4);
    check_eq("d_only/pulses", pulses - p0, 0);
    check_model("d_only");

    press(4'b0100, 4'b0100, 2, DEB + 4, "pre_zero");
    dec_zero = 1'b1;
    press(4'b0001, 4'b0001, 2, DEB + 4, "zero_step");
    dec_zero = 1'b0;

    for (int i = 0; i < 23; i++) press(4'b1111, 4'b1111, 0, DEB + 4, "sat_neg");
    check_eq("sat_neg/total", total, 8'h80);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) do_clr("rand_clr");
      press(rand_keys(), rand_keys(), $urandom_range(0, 15),
            $urandom_range(DEB + 4, DEB + 10), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
